// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types, limits and narrowing helper for the 5/3 lifting stage.
package dwt_pkg;
   typedef logic signed [15:0] coef_t;
   typedef logic signed [17:0] wide_t;
   typedef enum logic [1:0] {S_FIRST, S_ODD, S_EVEN, S_FLUSH} lift_state_e;
   localparam wide_t COEF_MAX = 18'sd32767;
   localparam wide_t COEF_MIN = -18'sd32768;
   function automatic coef_t sat16(input wide_t v);
      return v > COEF_MAX ? coef_t'(COEF_MAX) : v < COEF_MIN ? coef_t'(COEF_MIN) : coef_t'(v);
   endfunction
endpackage

// File: rtl/lift53_datapath.sv
// lift53_datapath: combinational 5/3 predict/update for one sample pair.
module lift53_datapath
   import dwt_pkg::*;
#(
   parameter bit SAT_EN = 1'b1
) (
   input  coef_t xe,
   input  coef_t xo,
   input  coef_t xn,
   input  coef_t dp,
   input  logic  first,
   output coef_t d,
   output coef_t s
);
   wide_t d_w, s_w;
   always_comb begin
      d_w = wide_t'(xo) - ((wide_t'(xe) + wide_t'(xn)) >>> 1);
      d   = SAT_EN ? sat16(d_w) : coef_t'(d_w);
      // the first pair mirrors its own detail in place of d[-1]
      s_w = wide_t'(xe) + ((wide_t'(first ? d : dp) + wide_t'(d) + 18'sd2) >>> 2);
      s   = SAT_EN ? sat16(s_w) : coef_t'(s_w);
   end
endmodule

// File: rtl/dwt_lift53_fwd.sv
// dwt_lift53_fwd: one-level forward 5/3 lifting over a block, writing s/d pairs to twin fifos.
module dwt_lift53_fwd
   import dwt_pkg::*;
#(
   parameter int BLOCK_LEN = 8,
   parameter bit SAT_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic [15:0] a_data,
   output logic        a_wr_en,
   input  logic        a_full,
   output logic [15:0] d_data,
   output logic        d_wr_en,
   input  logic        d_full,
   output logic        blk_done
);
   localparam int KW = $clog2(BLOCK_LEN);
   lift_state_e   state;
   coef_t         xe, xo, dp, d, s;
   logic [KW-1:0] k;
   logic          first, last_pair, out_pend, accept, wr;
   assign in_ready = reset && !out_pend && state != S_FLUSH;
   assign wr       = reset && out_pend && !a_full && !d_full;
   assign a_wr_en  = wr;
   assign d_wr_en  = wr;
   assign blk_done = wr && last_pair;
   assign accept   = in_valid && in_ready;
   // in flush the right neighbour x[BLOCK_LEN] is the mirrored x[BLOCK_LEN-2]
   lift53_datapath #(.SAT_EN(SAT_EN)) u_dp (
      .xe    (xe),
      .xo    (xo),
      .xn    (state == S_FLUSH ? xe : coef_t'(in_data)),
      .dp    (dp),
      .first (first),
      .d     (d),
      .s     (s)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_FIRST;
         xe        <= '0;
         xo        <= '0;
         dp        <= '0;
         k         <= '0;
         first     <= 1'b0;
         last_pair <= 1'b0;
         out_pend  <= 1'b0;
         a_data    <= '0;
         d_data    <= '0;
      end else begin
         if (wr) begin
            out_pend  <= 1'b0;
            last_pair <= 1'b0;
         end
         if (accept)
            k <= (k == KW'(BLOCK_LEN - 1)) ? '0 : k + 1'b1;
         case (state)
            S_FIRST: if (accept) begin
               xe    <= in_data;
               first <= 1'b1;
               state <= S_ODD;
            end
            S_ODD: if (accept) begin
               xo    <= in_data;
               state <= (k == KW'(BLOCK_LEN - 1)) ? S_FLUSH : S_EVEN;
            end
            S_EVEN: if (accept) begin
               a_data   <= s;
               d_data   <= d;
               out_pend <= 1'b1;
               xe       <= in_data;
               dp       <= d;
               first    <= 1'b0;
               state    <= S_ODD;
            end
            S_FLUSH: begin
               a_data    <= s;
               d_data    <= d;
               out_pend  <= 1'b1;
               last_pair <= 1'b1;
               state     <= S_FIRST;
            end
         endcase
      end
   end
endmodule

// File: doc/dwt_lift53_fwd.md
Name: dwt_lift53_fwd

Overview:
Forward integer 5/3 lifting stage, one decomposition level, for a 1-D block of BLOCK_LEN signed 16-bit samples.
- Accepts samples over a valid/ready stream.
- Produces one approximation coefficient s[n] and one detail coefficient d[n] per sample pair.
- Sits directly upstream of two 16-bit fifo instances (approximation fifo, detail fifo). Writes each coefficient pair into both fifos in the same cycle, honouring their full flags.

Parameters:
- BLOCK_LEN, 8, samples per block; even, >= 4.
- SAT_EN, 1, 1 = saturate coefficients to signed 16-bit; 0 = truncate (wrap).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset (asserted when 0).
- in_valid, input, 1, in_data holds a valid sample.
- in_ready, output, 1, block accepts a sample this cycle.
- in_data, input, 16, signed sample x[k].
- a_data, output, 16, signed approximation s[n], to fifo data_in.
- a_wr_en, output, 1, write strobe to approximation fifo.
- a_full, input, 1, approximation fifo full.
- d_data, output, 16, signed detail d[n], to fifo data_in.
- d_wr_en, output, 1, write strobe to detail fifo.
- d_full, input, 1, detail fifo full.
- blk_done, output, 1, one-cycle pulse when the last pair of a block is written.

Behaviour:
- Reset (reset=0, async): state=S_FIRST, all sample/detail registers 0, out_pend=0, a_data=d_data=0, blk_done=0. Outputs in_ready, a_wr_en and d_wr_en are 0 while reset is asserted.
- Accept: a sample is accepted when in_valid && in_ready. The sample index k counts 0..BLOCK_LEN-1 and wraps to 0 after the last sample.
- Math uses 18-bit signed intermediates. Floor is an arithmetic shift right.
  - d[n] = x[2n+1] - ((x[2n] + x[2n+2]) >>> 1)
  - s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2)
- Symmetric extension:
  - x[BLOCK_LEN] := x[BLOCK_LEN-2]
  - d[-1] := d[0]
- Narrowing: with SAT_EN=1, results clamp to [-32768, 32767]. With SAT_EN=0, keep the low 16 bits. Unclamped d[n] is never fed back; the clamped/truncated value is used as d[n-1].
- States:
  - S_FIRST: wait for x[0]; store it as xe → S_ODD.
  - S_ODD: accept x[2n+1] into xo. If it is the last sample of the block → S_FLUSH, else → S_EVEN.
  - S_EVEN: accept x[2n+2]. Compute d[n] and s[n] into the output registers, set out_pend, xe←x[2n+2], dp←d[n] → S_ODD.
  - S_FLUSH: compute the last pair using the extension, set out_pend, assert the last-pair flag → S_FIRST.
- Output handshake:
  - a_wr_en = d_wr_en = out_pend && !a_full && !d_full, combinational.
  - Never write one fifo without the other.
  - out_pend clears on the write cycle.
  - in_ready = !out_pend && state != S_FLUSH.
- Latency: a pair is registered on the cycle after its completing sample is accepted. It is written that cycle if neither fifo is full.
- Throughput: with no backpressure, one sample is accepted every cycle except one bubble per pair (the write cycle). Target is BLOCK_LEN + BLOCK_LEN/2 + 1 cycles per block.
- Backpressure: out_pend holds a_data/d_data stable until both fifos are non-full. No sample is lost and none is duplicated.
- blk_done pulses in the cycle the last pair's wr_en is asserted.
- First pair: d[-1] uses d[0], selected by a first-pair flag set in S_FIRST.
- Reset mid-block discards the partial block; the next accepted sample is x[0].
- in_valid low in any state: hold the current state.

Decomposition:
- Package dwt_pkg:
  - typedef coef_t (logic signed [15:0])
  - typedef wide_t (logic signed [17:0])
  - state enum lift_state_e
  - constants COEF_MAX = 32767, COEF_MIN = -32768
  - function sat16(wide_t) → coef_t
- Sub-module lift53_datapath: purely combinational. Inputs xe, xo, xn, dp, first; outputs d, s; contains the lifting arithmetic and saturation.
- The FSM, registers and handshake stay in dwt_lift53_fwd.

Test Plan:
- Ramp 0..7, no backpressure → d = {0,0,0,1}, s = {0,2,4,6}; blk_done once; 13 cycles from the first accept to blk_done.
- Constant 100 ×8 → d = {0,0,0,0}, s = {100,100,100,100}.
- Impulse {0,0,0,8,0,0,0,0} → d = {0,8,0,0}, s = {0,2,2,0}.
- Saturation: {-32768, 32767, -32768, 32767, ...} with SAT_EN=1 → every d = 32767; with SAT_EN=0 → d = -1 (wrapped 65535).
- Backpressure: hold d_full=1 for 5 cycles during pair 1 → a_wr_en and d_wr_en stay 0, in_ready=0, data stable; after release, output matches the ramp case exactly.
- Reset: assert reset=0 after 3 samples, then send the ramp → outputs, counts and blk_done identical to the first scenario; all outputs 0 during reset.
